gf180mcu_osu_sc_gp12t3v3__strap_ctrl: RTL and testbench

Serially loaded, lockable constant-strap generator for the gp12t3v3 library. It holds a bank of WIDTH static outputs that behave as tie-high/tie-low drivers. The outputs come out of reset at a fixed pattern and can be reprogrammed through a bit-serial shift/commit handshake until a one-way lock freezes them. It sits between the test/config port and any macro that would otherwise be strapped with tieh/tiel cells.

---
 rtl/gf180mcu_osu_sc_gp12t3v3__strap_ctrl.sv | 143 ++++++++++++++
 tb/tb_gf180mcu_osu_sc_gp12t3v3__strap_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_osu_sc_gp12t3v3__strap_ctrl.sv
// Serially loaded, lockable tie-high/tie-low strap bank: MSB-first shift into a shadow, COMMIT copies it to Y.
// Latency: Y/DONE one cycle after the accepted COMMIT; no backpressure, BUSY is advisory and LOCK is one-way until RN.
module gf180mcu_osu_sc_gp12t3v3__strap_ctrl #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             SI,
  input  logic             SE,
  input  logic             COMMIT,
  input  logic             LOCK,
  output logic [WIDTH-1:0] Y,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic             LOCKED
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_APPLY,
    ST_LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             lock_pend_q, lock_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic [WIDTH-1:0] shadow_shifted;

  assign shadow_shifted = {shadow_q[WIDTH-2:0], SI};

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      y_q         <= RESET_VAL;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      lock_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      lock_pend_q <= lock_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    lock_pend_d = lock_pend_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A pending lock is honoured ahead of a new shift, like a fresh LOCK.
        if (COMMIT) begin
          err_d       = 1'b1;
          lock_pend_d = lock_pend_q | LOCK;
        end else if (LOCK || lock_pend_q) begin
          state_d = ST_LOCKED;
        end else if (SE) begin
          shadow_d = shadow_shifted;
          cnt_d    = CW'(1);
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        lock_pend_d = lock_pend_q | LOCK;
        if (COMMIT) begin
          if (!SE && (cnt_q == CNT_FULL) && !ovf_q) begin
            state_d = ST_APPLY;
          end else begin
            err_d   = 1'b1;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (SE) begin
          shadow_d = shadow_shifted;
          if (cnt_q == CNT_FULL) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ST_APPLY: begin
        y_d         = shadow_q;
        done_d      = 1'b1;
        cnt_d       = '0;
        lock_pend_d = lock_pend_q | LOCK;
        state_d     = lock_pend_q ? ST_LOCKED : ST_IDLE;
      end

      ST_LOCKED: begin
        err_d = COMMIT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d   = (state_d == ST_SHIFT) || (state_d == ST_APPLY);
  assign locked_d = (state_q == ST_LOCKED);

  assign Y      = y_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign ERR    = err_q;
  assign LOCKED = locked_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__strap_ctrl.sv
// Directed bench for the strap controller: bit-count based reference model plus literal spot checks.
module tb_gf180mcu_osu_sc_gp12t3v3__strap_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RN, SI, SE, COMMIT, LOCK;
  logic [W-1:0] Y;
  logic         BUSY, DONE, ERR, LOCKED;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  gf180mcu_osu_sc_gp12t3v3__strap_ctrl #(
    .WIDTH    (W),
    .RESET_VAL(8'hFF)
  ) dut (
    .CLK   (CLK),
    .RN    (RN),
    .SI    (SI),
    .SE    (SE),
    .COMMIT(COMMIT),
    .LOCK  (LOCK),
    .Y     (Y),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .ERR   (ERR),
    .LOCKED(LOCKED)
  );

  always #5 CLK = ~CLK;

  // Reference model: counts accepted bits in the current load and keeps the last W of them.
  logic [W-1:0] m_y, acc;
  bit           m_busy, m_done, m_err, m_locked_out;
  bit           applying, lockreq, locked, m_lo;
  int           nb;

  task automatic model_reset();
    m_y = 8'hFF; acc = '0;
    m_busy = 0; m_done = 0; m_err = 0; m_locked_out = 0;
    applying = 0; lockreq = 0; locked = 0; nb = 0;
  endtask

  always @(posedge CLK or negedge RN) begin
    if (!RN) begin
      model_reset();
    end else begin
      m_lo   = locked;
      m_done = 0;
      m_err  = 0;
      if (locked) begin
        m_err = COMMIT;
      end else if (applying) begin
        m_y      = acc;
        m_done   = 1;
        applying = 0;
        nb       = 0;
        if (lockreq) locked = 1;
        if (LOCK) lockreq = 1;
      end else if (nb == 0) begin
        if (COMMIT) begin
          m_err = 1;
          if (LOCK) lockreq = 1;
        end else if (LOCK || lockreq) begin
          locked = 1;
        end else if (SE) begin
          acc = {acc[W-2:0], SI};
          nb  = 1;
        end
      end else begin
        if (LOCK) lockreq = 1;
        if (COMMIT) begin
          if (!SE && nb == W) applying = 1;
          else begin
            m_err = 1;
            nb    = 0;
          end
        end else if (SE) begin
          acc = {acc[W-2:0], SI};
          nb  = nb + 1;
        end
      end
      m_busy       = (nb > 0) || applying;
      m_locked_out = m_lo;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model_Y", Y, m_y);
      chk("model_BUSY", BUSY, m_busy);
      chk("model_DONE", DONE, m_done);
      chk("model_ERR", ERR, m_err);
      chk("model_LOCKED", LOCKED, m_locked_out);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic shift_bits(input logic [15:0] val, input int n, input int lock_at);
    for (int i = 0; i < n; i++) begin
      SE   = 1'b1;
      SI   = val[n-1-i];
      LOCK = (i + 1 == lock_at);
      tick();
    end
    SE = 1'b0; SI = 1'b0; LOCK = 1'b0;
  endtask

  task automatic commit();
    COMMIT = 1'b1;
    tick();
    COMMIT = 1'b0;
  endtask

  task automatic do_reset();
    RN = 1'b0;
    #1;
    chk("rst_Y", Y, 8'hFF);
    chk("rst_BUSY", BUSY, 1'b0);
    chk("rst_DONE", DONE, 1'b0);
    chk("rst_ERR", ERR, 1'b0);
    chk("rst_LOCKED", LOCKED, 1'b0);
    tick();
    RN = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    RN = 1'b1; SI = 1'b0; SE = 1'b0; COMMIT = 1'b0; LOCK = 1'b0;
    #1;
    chk_en = 1'b1;
    do_reset();

    // Normal load of 8'hA5, MSB first.
    shift_bits(16'h00A5, 8, 0);
    chk("load_busy", BUSY, 1'b1);
    chk("load_y_hold", Y, 8'hFF);
    commit();
    chk("apply_y_hold", Y, 8'hFF);
    chk("apply_done_low", DONE, 1'b0);
    tick();
    chk("load_y", Y, 8'hA5);
    chk("load_done", DONE, 1'b1);
    chk("load_err", ERR, 1'b0);
    chk("load_busy_fall", BUSY, 1'b0);
    tick();
    chk("done_pulse_end", DONE, 1'b0);

    do_reset();

    // Short load.
    shift_bits(16'h005A, 7, 0);
    commit();
    chk("short_err", ERR, 1'b1);
    chk("short_busy", BUSY, 1'b0);
    chk("short_y", Y, 8'hFF);
    tick();
    chk("short_err_end", ERR, 1'b0);

    // Overflow load.
    shift_bits(16'h0133, 9, 0);
    commit();
    chk("ovf_err", ERR, 1'b1);
    chk("ovf_busy", BUSY, 1'b0);
    chk("ovf_y", Y, 8'hFF);
    tick();

    // SE and COMMIT together after 7 bits.
    shift_bits(16'h007F, 7, 0);
    SE = 1'b1; SI = 1'b1; COMMIT = 1'b1;
    tick();
    SE = 1'b0; SI = 1'b0; COMMIT = 1'b0;
    chk("secommit_err", ERR, 1'b1);
    chk("secommit_y", Y, 8'hFF);
    chk("secommit_busy", BUSY, 1'b0);
    tick();

    // COMMIT while idle.
    commit();
    chk("idle_commit_err", ERR, 1'b1);
    chk("idle_commit_busy", BUSY, 1'b0);
    tick();

    // LOCK and SE together in idle: lock wins, nothing shifted.
    LOCK = 1'b1; SE = 1'b1; SI = 1'b1;
    tick();
    LOCK = 1'b0; SE = 1'b0; SI = 1'b0;
    chk("lockse_busy", BUSY, 1'b0);
    chk("lockse_locked_lag", LOCKED, 1'b0);
    tick();
    chk("lockse_locked", LOCKED, 1'b1);
    chk("lockse_y", Y, 8'hFF);
    commit();
    chk("locked_commit_err", ERR, 1'b1);

    do_reset();

    // Deferred lock raised on the 4th bit of 8'h3C.
    shift_bits(16'h003C, 8, 4);
    commit();
    tick();
    chk("defer_y", Y, 8'h3C);
    chk("defer_done", DONE, 1'b1);
    chk("defer_locked_lag", LOCKED, 1'b0);
    tick();
    chk("defer_locked", LOCKED, 1'b1);
    shift_bits(16'h0055, 8, 0);
    commit();
    chk("defer_reload_err", ERR, 1'b1);
    chk("defer_reload_y", Y, 8'h3C);
    tick();
    chk("defer_reload_y2", Y, 8'h3C);

    do_reset();

    // Reset while APPLY of 8'h00 is pending.
    shift_bits(16'h0000, 8, 0);
    commit();
    RN = 1'b0;
    #1;
    chk("midrst_y", Y, 8'hFF);
    chk("midrst_locked", LOCKED, 1'b0);
    chk("midrst_busy", BUSY, 1'b0);
    tick();
    RN = 1'b1;
    tick();
    chk("midrst_idle_y", Y, 8'hFF);
    shift_bits(16'h0081, 8, 0);
    commit();
    tick();
    chk("reload_y", Y, 8'h81);
    chk("reload_done", DONE, 1'b1);

    // Back-to-back load starting in the DONE cycle.
    shift_bits(16'h0042, 8, 0);
    commit();
    tick();
    chk("b2b_y", Y, 8'h42);
    chk("b2b_done", DONE, 1'b1);

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
